// File: rtl/riscv_core_trap_pkg.sv
// riscv_core_trap_pkg: shared CSR addresses, trap codes, CSR op and FSM state types
package riscv_core_trap_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam int IRQ_MTI        = 7;
  localparam int IRQ_MEI        = 11;
  localparam int IRQ_LOCAL_BASE = 16;
  localparam logic [4:0] EXC_INSN_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_ILLEGAL_INSN    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT      = 5'd3;
  localparam logic [4:0] EXC_LOAD_FAULT      = 5'd5;
  localparam logic [4:0] EXC_STORE_FAULT     = 5'd7;
  localparam logic [4:0] EXC_ECALL_M         = 5'd11;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP,
    S_RET,
    S_REDIRECT
  } state_e;
endpackage

// File: rtl/riscv_core_trap_irq_prio.sv
// riscv_core_trap_irq_prio: fixed-priority encoder MEI > MTI > local[0..N-1] over enabled pending interrupts
module riscv_core_trap_irq_prio
  import riscv_core_trap_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int NUM_LOCAL_IRQ = 16,
  parameter int CODE_W        = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]   irq_vec,
  output logic              irq_pending,
  output logic [CODE_W-1:0] irq_code
);
  always_comb begin
    irq_pending = |irq_vec;
    irq_code = '0;
    for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--)
      if (irq_vec[IRQ_LOCAL_BASE + k]) irq_code = CODE_W'(IRQ_LOCAL_BASE + k);
    if (irq_vec[IRQ_MTI]) irq_code = CODE_W'(IRQ_MTI);
    if (irq_vec[IRQ_MEI]) irq_code = CODE_W'(IRQ_MEI);
  end
endmodule

// File: rtl/riscv_core_trap_ctrl.sv
// riscv_core_trap_ctrl: machine-mode trap CSRs, trap/MRET sequencing and redirect handshake (vectored mtvec under TRAP_CTRL_VECTORED_EN)
module riscv_core_trap_ctrl
  import riscv_core_trap_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter int              NUM_LOCAL_IRQ = 16,
  parameter logic [XLEN-1:0] RESET_MTVEC   = '0
) (
  input  logic                     i_trap_ctrl_clk,
  input  logic                     i_trap_ctrl_rst,
  input  logic                     i_trap_ctrl_csr_wen,
  input  logic [1:0]               i_trap_ctrl_csr_op,
  input  logic [11:0]              i_trap_ctrl_csr_addr,
  input  logic [XLEN-1:0]          i_trap_ctrl_csr_src,
  output logic [XLEN-1:0]          o_trap_ctrl_csr_rdata,
  input  logic                     i_trap_ctrl_exc_valid,
  input  logic [4:0]               i_trap_ctrl_exc_cause,
  input  logic [XLEN-1:0]          i_trap_ctrl_exc_pc,
  input  logic [XLEN-1:0]          i_trap_ctrl_exc_tval,
  input  logic                     i_trap_ctrl_mret,
  input  logic [XLEN-1:0]          i_trap_ctrl_commit_pc,
  input  logic                     i_trap_ctrl_commit_pc_valid,
  input  logic                     i_trap_ctrl_meip,
  input  logic                     i_trap_ctrl_mtip,
  input  logic [NUM_LOCAL_IRQ-1:0] i_trap_ctrl_local_irq,
  output logic                     o_trap_ctrl_flush,
  output logic                     o_trap_ctrl_busy,
  output logic                     o_trap_ctrl_redirect_valid,
  input  logic                     i_trap_ctrl_redirect_ready,
  output logic [XLEN-1:0]          o_trap_ctrl_redirect_pc
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIE_MASK = ((((XLEN'(1) << NUM_LOCAL_IRQ) - XLEN'(1)) << IRQ_LOCAL_BASE)
                                         | (XLEN'(1) << IRQ_MEI) | (XLEN'(1) << IRQ_MTI));
`ifdef TRAP_CTRL_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_MASK = '1;
`else
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif
  state_e state, state_nx;
  logic mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mie_q, mip_q, mip_nx, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [XLEN-1:0] redirect_pc_q, trap_target, csr_wdata, mstatus_rd;
  logic irq_pending, irq_ok, irq_take, idle, accept, csr_we;
  logic [CW-1:0] irq_code;
  logic [11:0] addr;

  riscv_core_trap_irq_prio #(
    .XLEN(XLEN),
    .NUM_LOCAL_IRQ(NUM_LOCAL_IRQ),
    .CODE_W(CW)
  ) u_irq_prio (
    .irq_vec(mie_q & mip_q),
    .irq_pending(irq_pending),
    .irq_code(irq_code)
  );

  assign addr     = i_trap_ctrl_csr_addr;
  assign idle     = state == S_IDLE;
  assign irq_ok   = mstatus_mie & irq_pending & i_trap_ctrl_commit_pc_valid;
  assign irq_take = idle & ~i_trap_ctrl_exc_valid & irq_ok;
  assign accept   = idle & (i_trap_ctrl_exc_valid | irq_ok | i_trap_ctrl_mret);
  assign csr_we   = idle & ~accept & i_trap_ctrl_csr_wen & (i_trap_ctrl_csr_op != CSR_NONE);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_rd[MSTATUS_MIE] = mstatus_mie;
    mip_nx = '0;
    mip_nx[IRQ_MEI] = i_trap_ctrl_meip;
    mip_nx[IRQ_MTI] = i_trap_ctrl_mtip;
    mip_nx[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = i_trap_ctrl_local_irq;
  end

  assign o_trap_ctrl_csr_rdata = addr == CSR_MSTATUS  ? mstatus_rd :
                                 addr == CSR_MIE      ? mie_q :
                                 addr == CSR_MIP      ? mip_q :
                                 addr == CSR_MTVEC    ? mtvec_q :
                                 addr == CSR_MSCRATCH ? mscratch_q :
                                 addr == CSR_MEPC     ? mepc_q :
                                 addr == CSR_MCAUSE   ? mcause_q :
                                 addr == CSR_MTVAL    ? mtval_q : '0;

  assign csr_wdata = i_trap_ctrl_csr_op == CSR_RW ? i_trap_ctrl_csr_src :
                     i_trap_ctrl_csr_op == CSR_RS ? o_trap_ctrl_csr_rdata | i_trap_ctrl_csr_src :
                                                    o_trap_ctrl_csr_rdata & ~i_trap_ctrl_csr_src;

  always_comb begin
    trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1]) trap_target = trap_target + (mcause_q << 2);
`endif
  end

  always_ff @(posedge i_trap_ctrl_clk)
    state <= i_trap_ctrl_rst ? S_IDLE : state_nx;

  always_comb
    state_nx = state == S_IDLE     ? (i_trap_ctrl_exc_valid | irq_ok ? S_TRAP :
                                      i_trap_ctrl_mret ? S_RET : S_IDLE) :
               state == S_REDIRECT ? (i_trap_ctrl_redirect_ready ? S_IDLE : S_REDIRECT) :
                                     S_REDIRECT;

  always_comb begin
    o_trap_ctrl_flush = state == S_TRAP || state == S_RET;
    o_trap_ctrl_busy = state != S_IDLE;
    o_trap_ctrl_redirect_valid = state == S_REDIRECT;
  end

  assign o_trap_ctrl_redirect_pc = redirect_pc_q;

  always_ff @(posedge i_trap_ctrl_clk) begin
    if (i_trap_ctrl_rst) begin
      mstatus_mie <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q <= '0;
      mip_q <= '0;
      mtvec_q <= RESET_MTVEC & MTVEC_MASK;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      mscratch_q <= '0;
      redirect_pc_q <= '0;
    end else begin
      mip_q <= mip_nx;
      if (idle & i_trap_ctrl_exc_valid) begin
        mepc_q <= {i_trap_ctrl_exc_pc[XLEN-1:1], 1'b0};
        mcause_q <= XLEN'(i_trap_ctrl_exc_cause);
        mtval_q <= i_trap_ctrl_exc_tval;
      end else if (irq_take) begin
        mepc_q <= {i_trap_ctrl_commit_pc[XLEN-1:1], 1'b0};
        mcause_q <= {1'b1, (XLEN-1)'(irq_code)};
        mtval_q <= '0;
      end
      if (state == S_TRAP) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie <= 1'b0;
        redirect_pc_q <= trap_target;
      end
      if (state == S_RET) begin
        mstatus_mie <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        redirect_pc_q <= mepc_q;
      end
      if (csr_we) begin
        if (addr == CSR_MSTATUS) begin
          mstatus_mie <= csr_wdata[MSTATUS_MIE];
          mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
        end
        if (addr == CSR_MIE) mie_q <= csr_wdata & MIE_MASK;
        if (addr == CSR_MTVEC) mtvec_q <= csr_wdata & MTVEC_MASK;
        if (addr == CSR_MSCRATCH) mscratch_q <= csr_wdata;
        if (addr == CSR_MEPC) mepc_q <= {csr_wdata[XLEN-1:1], 1'b0};
        if (addr == CSR_MCAUSE) mcause_q <= csr_wdata;
        if (addr == CSR_MTVAL) mtval_q <= csr_wdata;
      end
    end
  end
endmodule

// File: tb/tb_riscv_core_trap_ctrl.sv
// tb_riscv_core_trap_ctrl: randomized and directed checks of the trap controller against a behavioural model
module tb_riscv_core_trap_ctrl;
  localparam int NL = 16;
`ifdef TRAP_CTRL_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, csr_wen, exc_valid, mret, cpv, meip, mtip, flush, busy, rv, ready;
  logic [1:0] csr_op;
  logic [11:0] csr_addr;
  logic [4:0] exc_cause;
  logic [63:0] csr_src, rdata, exc_pc, exc_tval, commit_pc, rpc;
  logic [NL-1:0] local_irq;

  riscv_core_trap_ctrl #(.XLEN(64), .NUM_LOCAL_IRQ(NL), .RESET_MTVEC(64'h0)) dut (
    .i_trap_ctrl_clk(clk),
    .i_trap_ctrl_rst(rst),
    .i_trap_ctrl_csr_wen(csr_wen),
    .i_trap_ctrl_csr_op(csr_op),
    .i_trap_ctrl_csr_addr(csr_addr),
    .i_trap_ctrl_csr_src(csr_src),
    .o_trap_ctrl_csr_rdata(rdata),
    .i_trap_ctrl_exc_valid(exc_valid),
    .i_trap_ctrl_exc_cause(exc_cause),
    .i_trap_ctrl_exc_pc(exc_pc),
    .i_trap_ctrl_exc_tval(exc_tval),
    .i_trap_ctrl_mret(mret),
    .i_trap_ctrl_commit_pc(commit_pc),
    .i_trap_ctrl_commit_pc_valid(cpv),
    .i_trap_ctrl_meip(meip),
    .i_trap_ctrl_mtip(mtip),
    .i_trap_ctrl_local_irq(local_irq),
    .o_trap_ctrl_flush(flush),
    .o_trap_ctrl_busy(busy),
    .o_trap_ctrl_redirect_valid(rv),
    .i_trap_ctrl_redirect_ready(ready),
    .o_trap_ctrl_redirect_pc(rpc)
  );

  int total = 0, bad = 0;
  bit m_known = 1'b0, m_ie, m_pie, m_ret;
  int m_ph;
  logic [63:0] m_mie_v, m_mip, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_tgt;
  logic [63:0] mie_mask;
  assign mie_mask = (64'hFFFF << 16) | 64'h880;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 | (64'(m_pie) << 7) | (64'(m_ie) << 3);
      12'h304: return m_mie_v;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      default: return 64'h0;
    endcase
  endfunction

  function automatic int m_code(input logic [63:0] v);
    if (v[11]) return 11;
    if (v[7]) return 7;
    for (int k = 0; k < NL; k++) if (v[16 + k]) return 16 + k;
    return -1;
  endfunction

  task automatic m_step();
    logic [63:0] old, nv, nmip;
    int c;
    if (rst) begin
      m_known = 1'b1; m_ph = 0; m_ie = 1'b0; m_pie = 1'b0; m_ret = 1'b0;
      m_mie_v = 0; m_mip = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
      return;
    end
    nmip = 0;
    nmip[11] = meip;
    nmip[7] = mtip;
    nmip[16 +: NL] = local_irq;
    if (m_ph == 0) begin
      c = m_code(m_mie_v & m_mip);
      if (exc_valid) begin
        m_mepc = exc_pc & ~64'h1; m_mcause = 64'(exc_cause); m_mtval = exc_tval;
        m_tgt = m_mtvec & ~64'h3; m_ret = 1'b0; m_ph = 1;
      end else if (m_ie && c >= 0 && cpv) begin
        m_mepc = commit_pc & ~64'h1; m_mcause = {1'b1, 63'(c)}; m_mtval = 0;
        m_tgt = (m_mtvec & ~64'h3) + ((VEC && m_mtvec[1:0] == 2'b01) ? 64'(4 * c) : 64'h0);
        m_ret = 1'b0; m_ph = 1;
      end else if (mret) begin
        m_tgt = m_mepc; m_ret = 1'b1; m_ph = 1;
      end else if (csr_wen && csr_op != 2'd0) begin
        old = m_read(csr_addr);
        nv = csr_op == 2'd1 ? csr_src : csr_op == 2'd2 ? (old | csr_src) : (old & ~csr_src);
        case (csr_addr)
          12'h300: begin m_ie = nv[3]; m_pie = nv[7]; end
          12'h304: m_mie_v = nv & mie_mask;
          12'h305: m_mtvec = VEC ? nv : (nv & ~64'h3);
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~64'h1;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          default: ;
        endcase
      end
    end else if (m_ph == 1) begin
      if (m_ret) begin m_ie = m_pie; m_pie = 1'b1; end
      else begin m_pie = m_ie; m_ie = 1'b0; end
      m_ph = 2;
    end else if (ready) m_ph = 0;
    m_mip = nmip;
  endtask

  task automatic tick();
    #1;
    if (m_known) begin
      chk("flush", 64'(flush), 64'(m_ph == 1));
      chk("busy", 64'(busy), 64'(m_ph != 0));
      chk("redirect_valid", 64'(rv), 64'(m_ph == 2));
      if (m_ph == 2) chk("redirect_pc", rpc, m_tgt);
      chk("csr_rdata", rdata, m_read(csr_addr));
    end
    m_step();
    @(negedge clk);
  endtask

  task automatic csr_w(input logic [11:0] a, input logic [1:0] op, input logic [63:0] s);
    csr_wen = 1'b1; csr_op = op; csr_addr = a; csr_src = s;
    tick();
    csr_wen = 1'b0; csr_op = 2'd0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1 chk(nm, rdata, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1; csr_wen = 0; csr_op = 0; csr_addr = 0; csr_src = 0; exc_valid = 0; exc_cause = 0;
    exc_pc = 0; exc_tval = 0; mret = 0; commit_pc = 0; cpv = 0; meip = 0; mtip = 0; local_irq = 0; ready = 0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    rd("reset_mstatus", 12'h300, 64'h1800);
    rd("reset_mtvec", 12'h305, 64'h0);
    rd("reset_mip", 12'h344, 64'h0);
    #1 chk("reset_redirect_valid", 64'(rv), 64'h0);
    tick();
    csr_w(12'h305, 2'd1, 64'h8000);
    csr_w(12'h300, 2'd2, 64'h8);
    csr_w(12'h304, 2'd2, 64'h800);
    meip = 1'b1;
    tick();
    commit_pc = 64'h100; cpv = 1'b1; ready = 1'b1;
    tick();
    meip = 1'b0; cpv = 1'b0;
    #1 chk("mei_flush", 64'(flush), 64'h1);
    tick();
    #1 chk("mei_redirect_pc", rpc, 64'h8000);
    tick();
    rd("mei_mepc", 12'h341, 64'h100);
    rd("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd("mei_mstatus", 12'h300, 64'h1880);
    csr_w(12'h300, 2'd2, 64'h8);
    csr_w(12'h304, 2'd2, 64'h80);
    mtip = 1'b1;
    tick(); tick();
    exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 64'hDEAD; exc_pc = 64'h200;
    cpv = 1'b1; commit_pc = 64'h300; ready = 1'b0;
    tick();
    exc_valid = 1'b0; cpv = 1'b0; mtip = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      exc_valid = 1'b1; mret = 1'b1; csr_wen = 1'b1; csr_op = 2'd1; csr_addr = 12'h340; csr_src = 64'h1234;
      #1 chk("stall_redirect_valid", 64'(rv), 64'h1);
      chk("stall_redirect_pc", rpc, 64'h8000);
      tick();
    end
    exc_valid = 1'b0; mret = 1'b0; csr_wen = 1'b0; csr_op = 2'd0; ready = 1'b1;
    tick();
    #1 chk("stall_release_busy", 64'(busy), 64'h0);
    rd("exc_mcause", 12'h342, 64'h2);
    rd("exc_mtval", 12'h343, 64'hDEAD);
    rd("exc_mepc", 12'h341, 64'h200);
    rd("exc_mscratch", 12'h340, 64'h0);
    csr_w(12'h305, 2'd1, 64'h8001);
    rd("vec_mtvec", 12'h305, VEC ? 64'h8001 : 64'h8000);
    csr_w(12'h300, 2'd2, 64'h8);
    csr_w(12'h304, 2'd2, 64'h1 << 19);
    local_irq = 16'h0008;
    tick();
    commit_pc = 64'h400; cpv = 1'b1;
    tick();
    cpv = 1'b0; local_irq = 16'h0;
    tick();
    #1 chk("local_redirect_pc", rpc, VEC ? 64'h804C : 64'h8000);
    tick();
    rd("local_mcause", 12'h342, 64'h8000_0000_0000_0013);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    #1 chk("mret_flush", 64'(flush), 64'h1);
    tick();
    #1 chk("mret_redirect_pc", rpc, 64'h400);
    tick();
    rd("mret_mstatus", 12'h300, 64'h1888);
    ready = 1'b0; exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 64'h500;
    tick();
    exc_valid = 1'b0;
    tick();
    #1 chk("pre_reset_redirect_valid", 64'(rv), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("post_reset_busy", 64'(busy), 64'h0);
    chk("post_reset_redirect_valid", 64'(rv), 64'h0);
    rd("post_reset_mstatus", 12'h300, 64'h1800);
    rd("post_reset_mtvec", 12'h305, 64'h0);
    rd("post_reset_mepc", 12'h341, 64'h0);
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] addrs [9];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
      rst = ($urandom % 300) == 0;
      csr_wen = ($urandom % 4) == 0;
      csr_op = 2'($urandom);
      csr_addr = addrs[$urandom % 9];
      csr_src = {$urandom, $urandom};
      exc_valid = ($urandom % 12) == 0;
      exc_cause = 5'($urandom);
      exc_pc = {$urandom, $urandom} & ~64'h1;
      exc_tval = {$urandom, $urandom};
      mret = ($urandom % 15) == 0;
      cpv = 1'($urandom);
      commit_pc = {$urandom, $urandom} & ~64'h1;
      if (($urandom % 10) == 0) meip = ~meip;
      if (($urandom % 10) == 0) mtip = ~mtip;
      if (($urandom % 6) == 0) local_irq = local_irq ^ (NL'(1) << ($urandom % NL));
      ready = ($urandom % 3) != 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
